// File: rtl/fir_seq_pkg.sv
// Shared types and helpers for the FIR channel sequencer.
// Channel search helpers work on an 8-bit view; narrower masks are zero-padded.
package fir_seq_pkg;

  localparam int MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SEND
  } state_t;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  // First set bit strictly after ptr, searching circularly; ptr itself last.
  function automatic logic [2:0] next_enabled(
    input logic [2:0]        ptr,
    input logic [MAX_CH-1:0] mask
  );
    logic [2:0] idx;
    logic       found;
    next_enabled = ptr;
    found        = 1'b0;
    for (int i = 1; i <= MAX_CH; i++) begin
      idx = ptr + 3'(i);
      if (!found && mask[idx]) begin
        next_enabled = idx;
        found        = 1'b1;
      end
    end
  endfunction

  function automatic logic [2:0] highest(
    input logic [MAX_CH-1:0] mask
  );
    highest = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (mask[i]) highest = 3'(i);
    end
  endfunction

endpackage

// File: rtl/fir_seq_hold.sv
// One-entry holding register for a single input channel.
// A disabled channel keeps ready high so its samples drain away.
module fir_seq_hold #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic              valid,
  output logic              ready,
  input  logic              take,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  assign ready = ~full | ~en;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      if (take) full <= 1'b0;
      if (valid && ready && en) begin
        full <= 1'b1;
        data <= sample;
      end
    end
  end

endmodule

// File: rtl/fir_channel_sequencer.sv
// Time-multiplexes per-channel sample streams into one FIR AXI-Stream,
// tagging each beat with its channel index in tuser.
module fir_channel_sequencer
  import fir_seq_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 24,
  parameter int CH_W        = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_arst,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [CH_W-1:0]          m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     cfg_enable,
  input  logic                     cfg_mode,
  input  logic [NUM_CH-1:0]        cfg_ch_mask,
  input  logic                     cfg_err_clr,
  output logic [NUM_CH-1:0]        err_timeout,
  output logic [15:0]              frame_cnt
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t state, state_d;

  logic              mode_q;
  logic [NUM_CH-1:0] mask_q;
  logic [2:0]        ptr, ptr_d, sel;
  logic [TMO_W-1:0]  tmo_cnt, tmo_d;
  logic [NUM_CH-1:0] full, take;
  logic [DATA_W-1:0] hold [NUM_CH];

  logic [MAX_CH-1:0] mask_w, full_w, cfg_w, take_w, err_w;
  logic [2:0]        rr_pick;
  logic              rr_hit;
  logic              load_out, latch_cfg, frame_inc;

  logic [DATA_W-1:0] tdata_q;
  logic [CH_W-1:0]   tuser_q;
  logic              tlast_q;
  logic [NUM_CH-1:0] err_q;
  logic [15:0]       frame_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_hold
    fir_seq_hold #(.DATA_W(DATA_W)) u_hold (
      .clk    (s_axis_aclk),
      .rst    (s_axis_arst),
      .en     (mask_q[g]),
      .sample (s_axis_tdata[g*DATA_W +: DATA_W]),
      .valid  (s_axis_tvalid[g]),
      .ready  (s_axis_tready[g]),
      .take   (take[g]),
      .full   (full[g]),
      .data   (hold[g])
    );
  end

  always_comb begin
    mask_w = '0;
    full_w = '0;
    cfg_w  = '0;
    mask_w[NUM_CH-1:0] = mask_q;
    full_w[NUM_CH-1:0] = full;
    cfg_w[NUM_CH-1:0]  = cfg_ch_mask;
  end

  // ptr already points past the last served channel, so search from ptr.
  assign rr_pick = next_enabled(ptr - 3'd1, mask_w & full_w);
  assign rr_hit  = |(mask_w & full_w);

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    tmo_d     = '0;
    sel       = ptr;
    take_w    = '0;
    err_w     = '0;
    load_out  = 1'b0;
    latch_cfg = 1'b0;
    frame_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_enable && |mask_q) begin
          state_d = WAIT;
          ptr_d   = next_enabled(3'(MAX_CH - 1), mask_w);
        end else begin
          latch_cfg = 1'b1;
        end
      end
      WAIT: begin
        if (!cfg_enable || mask_q == '0) begin
          state_d = IDLE;
        end else if (mode_q == MODE_RR) begin
          if (rr_hit) begin
            sel      = rr_pick;
            ptr_d    = rr_pick;
            load_out = 1'b1;
            state_d  = SEND;
          end
        end else if (full_w[ptr]) begin
          load_out = 1'b1;
          state_d  = SEND;
        end else if (tmo_cnt == TMO_LAST) begin
          err_w[ptr] = 1'b1;
          ptr_d      = next_enabled(ptr, mask_w);
        end else begin
          tmo_d = tmo_cnt + TMO_W'(1);
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          state_d = cfg_enable ? WAIT : IDLE;
          if (tlast_q) begin
            frame_inc = 1'b1;
            latch_cfg = 1'b1;
            ptr_d     = next_enabled(3'(MAX_CH - 1), cfg_w);
          end else begin
            ptr_d = next_enabled(ptr, mask_w);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_out) take_w[sel] = 1'b1;
  end

  assign take = take_w[NUM_CH-1:0];

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      state   <= IDLE;
      ptr     <= '0;
      tmo_cnt <= '0;
      mode_q  <= MODE_STRICT;
      mask_q  <= '0;
      tdata_q <= '0;
      tuser_q <= '0;
      tlast_q <= 1'b0;
      err_q   <= '0;
      frame_q <= '0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      tmo_cnt <= tmo_d;
      if (latch_cfg) begin
        mode_q <= cfg_mode;
        mask_q <= cfg_ch_mask;
      end
      if (load_out) begin
        tdata_q <= hold[sel];
        tuser_q <= CH_W'(sel);
        tlast_q <= (sel == highest(mask_w));
      end
      // A fresh timeout survives a simultaneous clear.
      err_q <= (err_q & ~{NUM_CH{cfg_err_clr}}) | err_w[NUM_CH-1:0];
      if (frame_inc) frame_q <= frame_q + 16'd1;
    end
  end

  assign m_axis_tvalid = (state == SEND);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign err_timeout   = err_q;
  assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_fir_channel_sequencer.sv
// Directed bench for fir_channel_sequencer with a per-channel scoreboard
// and a beat log checked against hand-written channel orders.
module tb_fir_channel_sequencer;

  localparam int NCH = 8;
  localparam int DW  = 24;
  localparam int CW  = 3;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tvalid, s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tready, m_tlast;
  logic [CW-1:0]     m_tuser;
  logic              en, mode, clr;
  logic [NCH-1:0]    mask, err;
  logic [15:0]       fcnt;

  always #5 clk = ~clk;

  fir_channel_sequencer #(
    .NUM_CH(NCH), .DATA_W(DW), .CH_W(CW), .TIMEOUT_CYC(TMO)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_arst   (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .cfg_enable    (en),
    .cfg_mode      (mode),
    .cfg_ch_mask   (mask),
    .cfg_err_clr   (clr),
    .err_timeout   (err),
    .frame_cnt     (fcnt)
  );

  int nchk = 0;
  int nerr = 0;
  int beats;
  int seqn [NCH];
  logic [DW-1:0]  exp_q [NCH][$];
  logic [2:0]     u_log [$];
  logic [15:0]    f_log [$];
  logic [NCH-1:0] e_log [$];
  logic [NCH-1:0] rdy_and;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] top_ch(logic [NCH-1:0] m);
    top_ch = '0;
    for (int i = 0; i < NCH; i++) if (m[i]) top_ch = 3'(i);
  endfunction

  task automatic set_src();
    for (int k = 0; k < NCH; k++)
      s_tdata[k*DW +: DW] = DW'(k * 16 + seqn[k] * 256);
  endtask

  task automatic step();
    logic [NCH-1:0] hs;
    logic           ohs, l;
    logic [2:0]     u;
    logic [DW-1:0]  d;
    hs  = s_tvalid & s_tready;
    ohs = m_tvalid & m_tready;
    u   = m_tuser;
    d   = m_tdata;
    l   = m_tlast;
    @(posedge clk);
    #1;
    if (ohs) begin
      beats++;
      u_log.push_back(u);
      f_log.push_back(fcnt);
      e_log.push_back(err);
      chk("tlast", 32'(l), 32'(u == top_ch(mask)));
      if (exp_q[u].size() == 0) chk("sb_avail", 0, 1);
      else chk("tdata", 32'(d), 32'(exp_q[u].pop_front()));
    end
    for (int k = 0; k < NCH; k++) begin
      if (hs[k]) begin
        if (mask[k]) exp_q[k].push_back(s_tdata[k*DW +: DW]);
        seqn[k]++;
      end
    end
    rdy_and = rdy_and & s_tready;
    set_src();
  endtask

  task automatic clear_tb();
    for (int k = 0; k < NCH; k++) begin
      exp_q[k].delete();
      seqn[k] = 0;
    end
    u_log.delete();
    f_log.delete();
    e_log.delete();
    beats   = 0;
    rdy_and = '1;
    set_src();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b0;
    s_tvalid = '0;
    step();
    step();
    rst = 1'b0;
    clear_tb();
  endtask

  task automatic start(logic [NCH-1:0] m, logic md, logic [NCH-1:0] v);
    mask = m;
    mode = md;
    en   = 1'b0;
    step();
    step();
    en       = 1'b1;
    s_tvalid = v;
  endtask

  task automatic run_beats(int n, int budget);
    int c = 0;
    while (beats < n && c < budget) begin
      step();
      c++;
    end
    chk("beats_reached", beats, n);
  endtask

  task automatic wait_tvalid(string tag);
    int c = 0;
    while (!m_tvalid && c < 20) begin
      step();
      c++;
    end
    chk(tag, 32'(m_tvalid), 1);
  endtask

  initial begin
    logic [2:0] seq2 [6];
    logic [2:0] seq3 [7];
    logic [2:0] seq4 [4];
    seq2 = '{3'd0, 3'd2, 3'd5, 3'd0, 3'd2, 3'd5};
    seq3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    seq4 = '{3'd6, 3'd1, 3'd6, 3'd1};
    rst      = 1'b1;
    en       = 1'b0;
    mode     = 1'b0;
    mask     = '0;
    clr      = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0;
    clear_tb();
    do_reset();

    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_sready", 32'(s_tready), 32'hFF);
    chk("rst_tdata", 32'(m_tdata), 0);
    chk("rst_tuser", 32'(m_tuser), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_fcnt", 32'(fcnt), 0);

    // strict order, all channels
    start(8'hFF, 1'b0, 8'hFF);
    run_beats(8, 100);
    for (int i = 0; i < 8; i++) chk("t1_user", 32'(u_log[i]), i);
    chk("t1_fcnt_pre", 32'(f_log[6]), 0);
    chk("t1_fcnt", 32'(f_log[7]), 1);

    // strict order, sparse mask
    do_reset();
    start(8'h25, 1'b0, 8'hFF);
    run_beats(6, 100);
    for (int i = 0; i < 6; i++) chk("t2_user", 32'(u_log[i]), 32'(seq2[i]));
    chk("t2_fcnt", 32'(f_log[5]), 2);
    chk("t2_rdy1", 32'(rdy_and[1]), 1);

    // strict order, channel 3 silent
    do_reset();
    start(8'hFF, 1'b0, 8'hF7);
    run_beats(7, 200);
    for (int i = 0; i < 7; i++) chk("t3_user", 32'(u_log[i]), 32'(seq3[i]));
    chk("t3_err_before", 32'(e_log[2]), 0);
    chk("t3_err_after", 32'(e_log[3]), 32'h08);
    chk("t3_fcnt", 32'(f_log[6]), 1);
    chk("t3_err_now", 32'(err), 32'h08);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t3_err_clr", 32'(err), 0);

    // round-robin, channels 6 and 1
    do_reset();
    m_tready = 1'b0;
    start(8'hFF, 1'b1, 8'h40);
    wait_tvalid("t4_tvalid");
    chk("t4_first_user", 32'(m_tuser), 6);
    s_tvalid = 8'h42;
    repeat (4) step();
    m_tready = 1'b1;
    run_beats(4, 100);
    for (int i = 0; i < 4; i++) chk("t4_user", 32'(u_log[i]), 32'(seq4[i]));
    chk("t4_err", 32'(err), 0);

    // long FIR stall
    do_reset();
    m_tready = 1'b0;
    start(8'hFF, 1'b0, 8'hFF);
    repeat (128) step();
    chk("t5_sready", 32'(s_tready), 0);
    chk("t5_tvalid", 32'(m_tvalid), 1);
    chk("t5_tuser", 32'(m_tuser), 0);
    chk("t5_acc0", seqn[0], 2);
    chk("t5_acc5", seqn[5], 1);
    m_tready = 1'b1;
    run_beats(16, 200);
    for (int i = 0; i < 16; i++) chk("t5_user", 32'(u_log[i]), i % 8);
    chk("t5_fcnt", 32'(f_log[15]), 2);

    // reset while stalled in SEND
    m_tready = 1'b0;
    wait_tvalid("t6_tvalid");
    chk("t6_fcnt_pre", 32'(fcnt), 2);
    rst = 1'b1;
    step();
    chk("t6_tvalid", 32'(m_tvalid), 0);
    chk("t6_sready", 32'(s_tready), 32'hFF);
    chk("t6_fcnt", 32'(fcnt), 0);
    rst = 1'b0;
    s_tvalid = '0;
    clear_tb();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
